bits_sched: RTL and testbench
=============================

# bits_sched

Sequencer and arbiter for the `bits` variable parallel-to-serial converter. It accepts 32-bit words from an upstream valid/ready source and variable-length field requests from NREQ requesters. It tracks the converter's bit fill level, so the converter never overflows its 1024-bit store and never serves a request longer than the bits it holds. It drives the converter's pushin/reqin ports and tags each converter output with the requester that asked for it.

## Interface
- CAP_BITS, 1024, converter storage capacity in bits
- WORD_W, 32, pushed word width
- LEN_W, 4, request length width (0..15 bits)
- NREQ, 2, number of requesters; ID_W = max(1, clog2(NREQ))
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- win_valid  in  1  upstream word valid
- win_data  in  WORD_W  upstream word
- win_ready  out  1  word accepted when win_valid && win_ready
- rq_valid  in  NREQ  per-requester request valid; held with rq_len until granted
- rq_len  in  NREQ*LEN_W  per-requester length, requester i at [i*LEN_W +: LEN_W]
- rq_grant  out  NREQ  one-hot or zero; request i accepted in the cycle rq_grant[i]=1
- conv_pushin, conv_datain, conv_reqin, conv_reqlen  out  1/WORD_W/1/LEN_W  converter inputs, registered
- conv_pushout, conv_lenout  in  1/LEN_W  converter outputs
- rsp_valid, rsp_id, rsp_len  out  1/ID_W/LEN_W  tagged response
- fill  out  11  bits currently committed to converter
- err  out  1  sticky protocol-mismatch flag

## Operation
- Room: win_ready = (fill <= CAP_BITS - WORD_W). The decision is combinational from registered fill only, not from a same-cycle request.
- Eligibility: requester i is eligible when rq_valid[i] && rq_len[i] <= fill. A len-0 request is always eligible. Pre-push fill is used, never fill plus a same-cycle push.
- Arbitration: round-robin, work-conserving. Search starts at pointer rr. The first eligible requester is granted. rr becomes grant index + 1 mod NREQ. rr is unchanged when there is no grant. An ineligible preferred requester is skipped.
- Push and grant are independent and may both occur in the same cycle.
- Fill update: fill_next = fill + (push ? WORD_W : 0) - (grant ? len : 0). Width 11 bits, unsigned.
- By construction, fill stays in 0..CAP_BITS. Any other value is a design bug and is flagged by assertion.
- Converter drive: the registers load on the decision cycle.
  - conv_pushin = push, conv_datain = win_data.
  - conv_reqin = grant, conv_reqlen = granted len.
  - When nothing is accepted, all four registers load 0.
- Tag pipeline: 2-stage shift of {req, id, len}, loaded from the conv_reqin stage.
- Response:
  - rsp_valid = conv_pushout.
  - rsp_id = pipe stage-2 id.
  - rsp_len = conv_lenout.
- Error: err sets when conv_pushout != pipe stage-2 req, or when both are 1 and conv_lenout != stage-2 len. err clears only on rst.

## Timing
- Decision cycle t: handshake on win and/or rq_grant.
- Cycle t+1: conv_pushin / conv_reqin high for exactly one cycle. fill reflects the update.
- Cycle t+3: conv_pushout and rsp_valid. Converter latency from conv_reqin is 2 cycles.
- Throughput: one word and one request per cycle, sustained.
- Full: at fill > CAP_BITS - WORD_W, win_ready = 0. It reasserts the cycle after fill drops to CAP_BITS - WORD_W or less.
- Empty: at fill = 0, only len-0 requests are granted. A word pushed in cycle t makes requests eligible in t+1.
- Reset: sampled on the edge. On reset:
  - Outputs: win_ready = 1 (fill is 0). All other outputs 0, including rq_grant, conv_*, rsp_*, fill and err.
  - Internal state: rr = 0 and the tag pipe is cleared.
  - Reset mid-operation discards in-flight tags. The converter shares rst, so no stale pushout follows.

## Structure
- Package bits_pkg holds WORD_W, LEN_W, CAP_BITS, FILL_W = 11, CONV_LAT = 2, and a tag struct {req, id, len}.
- Sub-module bits_rr_arb takes an NREQ eligibility mask and returns a one-hot grant. It owns the rr pointer and its update.
- Top level bits_sched holds the fill counter, room logic, converter drive registers, tag pipe and err.

## Test plan
- Reset: rst high 2 cycles, all inputs active -> every output 0 except win_ready = 1; fill = 0.
- Basic: push 0xA5A5A5A5, then rq0 len 8 -> grant one cycle after push; conv_reqin = 1 with reqlen 8 next cycle; rsp_valid, rsp_id 0, rsp_len 8 two cycles later; fill 32 -> 24.
- Underflow hold: fill 0, rq0 len 5 valid, word pushed at t -> no grant at t; grant at t+1; fill 32 -> 27.
- Full/wrap: push 32 words -> fill 1024, win_ready 0. Three len-15 grants -> fill 979 -> win_ready 1 next cycle. A simultaneous push and grant gives fill +17.
- Round-robin: fill 64, rq0 and rq1 valid len 4 -> grants 0,1,0,1. With fill 10, rq0 len 12, rq1 len 3 -> rq1 granted, rq0 held.
- Error: suppress conv_pushout when a response is expected -> err = 1 next cycle, stays 1 until rst.

Source files
------------

// File: rtl/bits_pkg.sv
// Shared constants and tag type for the bits converter sequencer.
// The tag follows each converter request so its output can be attributed to a requester.
package bits_pkg;
  localparam int WORD_W   = 32;
  localparam int LEN_W    = 4;
  localparam int CAP_BITS = 1024;
  localparam int FILL_W   = 11;
  localparam int CONV_LAT = 2;
  localparam int NREQ     = 2;
  localparam int ID_W     = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef struct packed {
    logic             req;
    logic [ID_W-1:0]  id;
    logic [LEN_W-1:0] len;
  } tag_t;

  function automatic logic [FILL_W-1:0] len2fill(input logic [LEN_W-1:0] len);
    return FILL_W'(len);
  endfunction
endpackage

// File: rtl/bits_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant from an eligibility mask, no backpressure.
// The search pointer advances past the winner; it holds when nothing is granted.
module bits_rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  elig_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);
  logic [IW-1:0] rr_q, rr_d;

  always_comb begin
    int            cand_i;
    logic [IW-1:0] cand;
    grant_o = '0;
    idx_o   = '0;
    vld_o   = 1'b0;
    rr_d    = rr_q;
    cand_i  = 0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand_i = int'(rr_q) + k;
      if (cand_i >= N) cand_i = cand_i - N;
      cand = IW'(cand_i);
      if (!vld_o && elig_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
    end
    if (vld_o) begin
      grant_o[idx_o] = 1'b1;
      rr_d = (int'(idx_o) + 1 >= N) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end
endmodule

// File: rtl/bits_sched.sv
// Word/request sequencer for the bits converter: fill tracking, arbitration, drive regs, tags.
// Decision to converter input is 1 cycle, response 3 cycles; win_ready drops when a word would overflow.
module bits_sched
  import bits_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    win_valid,
  input  logic [WORD_W-1:0]       win_data,
  output logic                    win_ready,
  input  logic [NREQ-1:0]         rq_valid,
  input  logic [NREQ*LEN_W-1:0]   rq_len,
  output logic [NREQ-1:0]         rq_grant,
  output logic                    conv_pushin,
  output logic [WORD_W-1:0]       conv_datain,
  output logic                    conv_reqin,
  output logic [LEN_W-1:0]        conv_reqlen,
  input  logic                    conv_pushout,
  input  logic [LEN_W-1:0]        conv_lenout,
  output logic                    rsp_valid,
  output logic [ID_W-1:0]         rsp_id,
  output logic [LEN_W-1:0]        rsp_len,
  output logic [FILL_W-1:0]       fill,
  output logic                    err
);
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              push;
  logic [NREQ-1:0]   elig;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_idx;
  logic [LEN_W-1:0]  gnt_len;

  logic              pushin_q;
  logic [WORD_W-1:0] datain_q;
  logic              reqin_q;
  logic [LEN_W-1:0]  reqlen_q;
  logic [ID_W-1:0]   reqid_q;
  tag_t              tag_q [CONV_LAT];
  tag_t              tail;
  logic              err_q, err_d;

  assign win_ready = (fill_q <= FILL_W'(CAP_BITS - WORD_W));
  assign push      = win_valid && win_ready;

  // Eligibility uses pre-push fill; reset masks len-0 requests that would otherwise win at fill 0.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = !rst && rq_valid[i] && (len2fill(rq_len[i*LEN_W +: LEN_W]) <= fill_q);
    end
  end

  bits_rr_arb #(.N(NREQ), .IW(ID_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .elig_i  (elig),
    .grant_o (rq_grant),
    .idx_o   (gnt_idx),
    .vld_o   (gnt_vld)
  );

  assign gnt_len = gnt_vld ? rq_len[gnt_idx*LEN_W +: LEN_W] : '0;
  assign fill_d  = fill_q + (push ? FILL_W'(WORD_W) : '0) - len2fill(gnt_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q   <= '0;
      pushin_q <= 1'b0;
      datain_q <= '0;
      reqin_q  <= 1'b0;
      reqlen_q <= '0;
      reqid_q  <= '0;
      for (int s = 0; s < CONV_LAT; s++) tag_q[s] <= '0;
      err_q    <= 1'b0;
    end else begin
      fill_q   <= fill_d;
      pushin_q <= push;
      datain_q <= push ? win_data : '0;
      reqin_q  <= gnt_vld;
      reqlen_q <= gnt_len;
      reqid_q  <= gnt_vld ? gnt_idx : '0;
      tag_q[0] <= '{req: reqin_q, id: reqid_q, len: reqlen_q};
      for (int s = 1; s < CONV_LAT; s++) tag_q[s] <= tag_q[s-1];
      err_q    <= err_d;
    end
  end

  assign tail  = tag_q[CONV_LAT-1];
  assign err_d = err_q
               | (conv_pushout != tail.req)
               | (conv_pushout && tail.req && (conv_lenout != tail.len));

  assign conv_pushin = pushin_q;
  assign conv_datain = datain_q;
  assign conv_reqin  = reqin_q;
  assign conv_reqlen = reqlen_q;
  assign rsp_valid   = conv_pushout;
  assign rsp_id      = tail.id;
  assign rsp_len     = conv_lenout;
  assign fill        = fill_q;
  assign err         = err_q;

  fill_in_range: assert property (@(posedge clk) disable iff (rst) fill_q <= FILL_W'(CAP_BITS));
endmodule

// File: tb/tb_bits_sched.sv
// Bench for bits_sched: behavioural fill/round-robin model, converter stand-in, response scoreboard.
module tb_bits_sched;
  import bits_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  win_valid, win_ready;
  logic [WORD_W-1:0]     win_data;
  logic [NREQ-1:0]       rq_valid, rq_grant;
  logic [NREQ*LEN_W-1:0] rq_len;
  logic                  conv_pushin, conv_reqin, conv_pushout;
  logic [WORD_W-1:0]     conv_datain;
  logic [LEN_W-1:0]      conv_reqlen, conv_lenout;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [LEN_W-1:0]      rsp_len;
  logic [FILL_W-1:0]     fill;
  logic                  err;

  bits_sched dut (
    .clk(clk), .rst(rst),
    .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
    .rq_valid(rq_valid), .rq_len(rq_len), .rq_grant(rq_grant),
    .conv_pushin(conv_pushin), .conv_datain(conv_datain),
    .conv_reqin(conv_reqin), .conv_reqlen(conv_reqlen),
    .conv_pushout(conv_pushout), .conv_lenout(conv_lenout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_len(rsp_len),
    .fill(fill), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Converter stand-in: echoes each request two cycles after conv_reqin; drop suppresses the echo.
  bit               drop = 1'b0;
  logic [1:0]       cv_p;
  logic [LEN_W-1:0] cv_l0, cv_l1;
  always @(posedge clk) begin
    if (rst) begin
      cv_p <= '0; cv_l0 <= '0; cv_l1 <= '0;
    end else begin
      cv_p[0] <= conv_reqin;
      cv_l0   <= conv_reqlen;
      cv_p[1] <= cv_p[0] & !drop;
      cv_l1   <= cv_l0;
    end
  end
  assign conv_pushout = cv_p[1];
  assign conv_lenout  = cv_l1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct { int due; int id; int len; } exp_t;
  exp_t q[$];
  bit   mon_en = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rsp_valid === 1'b1) begin
        if (q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
        else begin
          e = q.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_len", rsp_len, e.len);
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        chk("rsp_valid", rsp_valid, 1);
        void'(q.pop_front());
      end
    end
  end

  // Reference model state: bits held, next preferred requester, last-cycle converter drive.
  int          m_fill, m_rr, m_plen;
  bit          m_ppush, m_preq;
  logic [31:0] m_pdata;

  task automatic model_reset();
    m_fill = 0; m_rr = 0; m_plen = 0;
    m_ppush = 0; m_preq = 0; m_pdata = '0;
    q.delete();
  endtask

  task automatic step(input bit wv, input logic [31:0] wd, input logic [NREQ-1:0] rv,
                      input logic [NREQ*LEN_W-1:0] rl, output logic [NREQ-1:0] g_seen);
    int gid, idx;
    bit rdy, pu;
    int ln [NREQ];
    logic [NREQ-1:0] eg;
    exp_t e;
    win_valid = wv; win_data = wd; rq_valid = rv; rq_len = rl;
    #1;
    for (int i = 0; i < NREQ; i++) ln[i] = int'(rl[i*LEN_W +: LEN_W]);
    rdy = (m_fill + WORD_W <= CAP_BITS);
    pu  = wv && rdy;
    gid = -1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (m_rr + k) % NREQ;
      if (gid < 0 && rv[idx] && ln[idx] <= m_fill) gid = idx;
    end
    eg = '0;
    if (gid >= 0) eg[gid] = 1'b1;
    g_seen = rq_grant;
    chk("win_ready", win_ready, rdy);
    chk("rq_grant", rq_grant, eg);
    chk("fill", fill, m_fill);
    chk("conv_pushin", conv_pushin, m_ppush);
    chk("conv_datain", conv_datain, m_pdata);
    chk("conv_reqin", conv_reqin, m_preq);
    chk("conv_reqlen", conv_reqlen, m_plen);
    m_ppush = pu;
    m_pdata = pu ? wd : '0;
    m_preq  = (gid >= 0);
    m_plen  = (gid >= 0) ? ln[gid] : 0;
    if (pu) m_fill += WORD_W;
    if (gid >= 0) begin
      m_fill -= ln[gid];
      m_rr = (gid + 1) % NREQ;
      e.due = cyc + 3; e.id = gid; e.len = ln[gid];
      q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic [NREQ-1:0] g;
    repeat (n) step(1'b0, '0, '0, '0, g);
  endtask

  task automatic do_reset();
    #1;
    q.delete();
    rst = 1'b1; drop = 1'b0;
    win_valid = 0; win_data = '0; rq_valid = '0; rq_len = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [NREQ-1:0] g;
    bit               cv [NREQ];
    logic [LEN_W-1:0] cl [NREQ];
    logic [NREQ-1:0]  rv;
    logic [NREQ*LEN_W-1:0] rl;
    bit               wv;

    // Reset with every input active, including a len-0 request that must not be granted.
    win_valid = 1; win_data = '1; rq_valid = '1; rq_len = {4'd3, 4'd0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_win_ready", win_ready, 1);
    chk("rst_rq_grant", rq_grant, 0);
    chk("rst_conv_pushin", conv_pushin, 0);
    chk("rst_conv_datain", conv_datain, 0);
    chk("rst_conv_reqin", conv_reqin, 0);
    chk("rst_conv_reqlen", conv_reqlen, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_len", rsp_len, 0);
    chk("rst_fill", fill, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    model_reset();

    // Basic push then request.
    step(1, 32'hA5A5A5A5, 2'b00, 8'h00, g);
    chk("basic_fill_push", fill, 32);
    step(0, '0, 2'b01, {4'd0, 4'd8}, g);
    chk("basic_gnt", g, 2'b01);
    chk("basic_reqin", conv_reqin, 1);
    chk("basic_reqlen", conv_reqlen, 8);
    chk("basic_fill", fill, 24);
    idle(4);

    // Request waits for the word pushed in the same cycle.
    do_reset();
    step(1, 32'h12345678, 2'b01, {4'd0, 4'd5}, g);
    chk("uf_nogrant", g, 2'b00);
    step(0, '0, 2'b01, {4'd0, 4'd5}, g);
    chk("uf_grant", g, 2'b01);
    chk("uf_fill", fill, 27);
    idle(4);

    // Fill to capacity, drain below the room threshold, then push and grant together.
    do_reset();
    for (int i = 0; i < 32; i++) step(1, $urandom, 2'b00, 8'h00, g);
    chk("full_fill", fill, 1024);
    chk("full_ready", win_ready, 0);
    for (int i = 0; i < 3; i++) step(1, $urandom, 2'b01, {4'd0, 4'd15}, g);
    chk("drain_fill", fill, 979);
    chk("drain_ready", win_ready, 1);
    step(1, 32'hCAFEF00D, 2'b01, {4'd0, 4'd15}, g);
    chk("pushgnt_fill", fill, 996);
    idle(4);

    // Round-robin alternation, then an ineligible preferred requester is skipped.
    do_reset();
    step(1, $urandom, 2'b00, 8'h00, g);
    step(1, $urandom, 2'b00, 8'h00, g);
    chk("rr_fill", fill, 64);
    for (int j = 0; j < 4; j++) begin
      step(0, '0, 2'b11, {4'd4, 4'd4}, g);
      chk("rr_gnt", g, (j % 2 == 0) ? 2'b01 : 2'b10);
    end
    idle(4);
    do_reset();
    step(1, $urandom, 2'b00, 8'h00, g);
    step(0, '0, 2'b01, {4'd0, 4'd15}, g);
    step(0, '0, 2'b01, {4'd0, 4'd7}, g);
    chk("skip_fill", fill, 10);
    for (int j = 0; j < 3; j++) begin
      step(0, '0, 2'b11, {4'd3, 4'd12}, g);
      chk("skip_gnt", g, 2'b10);
    end
    chk("skip_fill_end", fill, 1);
    idle(4);

    // Randomised traffic: heavy push phase then a light push phase to exercise full and empty.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin cv[i] = 0; cl[i] = '0; end
    for (int n = 0; n < 3000; n++) begin
      wv = (n < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!cv[i] && $urandom_range(0, 1) == 1) begin
          cv[i] = 1;
          cl[i] = LEN_W'($urandom_range(0, 15));
        end
        rv[i] = cv[i];
        rl[i*LEN_W +: LEN_W] = cl[i];
      end
      step(wv, $urandom, rv, rl, g);
      for (int i = 0; i < NREQ; i++) if (g[i]) cv[i] = 0;
    end
    idle(6);
    chk("drain_queue", q.size(), 0);
    chk("err_clean", err, 0);

    // Missing converter response sets the sticky error.
    do_reset();
    mon_en = 0;
    drop = 1;
    step(1, $urandom, 2'b00, 8'h00, g);
    step(0, '0, 2'b01, {4'd0, 4'd4}, g);
    idle(2);
    chk("err_before", err, 0);
    idle(1);
    chk("err_set", err, 1);
    idle(5);
    chk("err_sticky", err, 1);
    do_reset();
    #1;
    chk("err_reset", err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
